// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/interrupt/MRET sequencer driving CSR writes and PC redirect (optional MTVAL via TRAP_MTVAL_EN)
module trap_ctrl #(
  parameter int IRQ_NUM = 4,
  parameter int ADDR_W  = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [IRQ_NUM-1:0]  irq_i,
  input  logic [IRQ_NUM-1:0]  irq_en_i,
  input  logic                global_int_en_i,
  input  logic [31:0]         inst_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  input  logic                illegal_inst_i,
  input  logic                jump_flag_i,
  input  logic [ADDR_W-1:0]   jump_addr_i,
  input  logic [31:0]         csr_mtvec,
  input  logic [31:0]         csr_mepc,
  input  logic [31:0]         csr_mstatus,
  output logic                hold_flag_o,
  output logic                we_o,
  output logic [31:0]         waddr_o,
  output logic [31:0]         data_o,
  output logic                int_assert_o,
  output logic [ADDR_W-1:0]   int_addr_o,
  output logic [IRQ_NUM-1:0]  irq_ack_o
);
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
`ifdef TRAP_MTVAL_EN
  typedef enum logic [2:0] {S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET, S_MTVAL} state_t;
  localparam state_t S_LAST = S_MTVAL;
`else
  typedef enum logic [2:0] {S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET} state_t;
  localparam state_t S_LAST = S_MCAUSE;
`endif
  state_t              r_state, w_next;
  logic [31:0]         r_cause;
  logic [ADDR_W-1:0]   r_epc;
  logic                r_async;
  logic                r_we, w_we;
  logic [31:0]         r_waddr, w_waddr, r_data, w_data;
  logic                r_int_assert, w_int_assert;
  logic [ADDR_W-1:0]   r_int_addr, w_int_addr;
  logic [IRQ_NUM-1:0]  r_ack;
  logic                w_idle, w_ecall, w_ebreak, w_mret, w_sync, w_async;
  logic                w_take_sync, w_take_async, w_take_mret;
  logic [IRQ_NUM-1:0]  w_pend, w_onehot;
  logic [4:0]          w_idx, w_code;
  logic [31:0]         w_sync_cause, w_irq_cause;
  logic [ADDR_W-1:0]   w_epc, w_base;
`ifdef TRAP_MTVAL_EN
  logic [31:0]         r_tval;
`endif
  assign w_idle       = r_state == S_IDLE;
  assign w_ecall      = inst_i == INST_ECALL;
  assign w_ebreak     = inst_i == INST_EBREAK;
  assign w_mret       = inst_i == INST_MRET;
  assign w_sync       = w_ecall | w_ebreak | illegal_inst_i;
  assign w_pend       = irq_i & irq_en_i;
  assign w_async      = (|w_pend) & global_int_en_i;
  assign w_take_sync  = w_idle & w_sync;
  assign w_take_async = w_idle & ~w_sync & w_async;
  assign w_take_mret  = w_idle & ~w_sync & ~w_async & w_mret;
  assign w_onehot     = w_pend & (~w_pend + IRQ_NUM'(1));
  assign w_sync_cause = illegal_inst_i ? 32'd2 : w_ecall ? 32'd11 : 32'd3;
  assign w_code       = (w_idx < 5'd3) ? {w_idx[2:0], 2'b11} : w_idx + 5'd13;
  assign w_irq_cause  = {1'b1, 26'd0, w_code};
  assign w_epc        = jump_flag_i ? jump_addr_i :
                        (w_sync & ~illegal_inst_i) ? inst_addr_i + ADDR_W'(4) : inst_addr_i;
  assign w_base       = csr_mtvec[ADDR_W-1:0] & ~ADDR_W'(3);
  assign hold_flag_o  = w_take_sync | w_take_async | w_take_mret | ~w_idle | r_int_assert;
  assign we_o         = r_we;
  assign waddr_o      = r_waddr;
  assign data_o       = r_data;
  assign int_assert_o = r_int_assert;
  assign int_addr_o   = r_int_addr;
  assign irq_ack_o    = r_ack;
  // lowest pending index wins
  always_comb begin
    w_idx = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) if (w_pend[i]) w_idx = i[4:0];
  end
  // next-state sequencing through the CSR write states
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = (w_take_sync | w_take_async) ? S_MEPC : w_take_mret ? S_MRET : S_IDLE;
      S_MEPC:    w_next = S_MSTATUS;
      S_MSTATUS: w_next = S_MCAUSE;
`ifdef TRAP_MTVAL_EN
      S_MCAUSE:  w_next = S_MTVAL;
      S_MTVAL:   w_next = S_IDLE;
`else
      S_MCAUSE:  w_next = S_IDLE;
`endif
      S_MRET:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  // next values of the registered CSR write and redirect outputs
  always_comb begin
    w_we         = ~w_idle;
    w_waddr      = 32'd0;
    w_data       = 32'd0;
    w_int_assert = (r_state == S_LAST) | (r_state == S_MRET);
    w_int_addr   = '0;
    case (r_state)
      S_MEPC:    begin w_waddr = 32'h341; w_data = 32'(r_epc); end
      S_MSTATUS: begin w_waddr = 32'h300; w_data = {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4], 1'b0, csr_mstatus[2:0]}; end
      S_MCAUSE:  begin w_waddr = 32'h342; w_data = r_cause; end
`ifdef TRAP_MTVAL_EN
      S_MTVAL:   begin w_waddr = 32'h343; w_data = r_tval; end
`endif
      S_MRET:    begin w_waddr = 32'h300; w_data = {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4], csr_mstatus[7], csr_mstatus[2:0]}; end
      default:   ;
    endcase
    if (r_state == S_MRET) w_int_addr = csr_mepc[ADDR_W-1:0];
    else if (r_state == S_LAST) w_int_addr = (r_async && csr_mtvec[1:0] == 2'b01) ? w_base + ADDR_W'({r_cause[4:0], 2'b00}) : w_base;
  end
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= S_IDLE;
    else r_state <= w_next;
  // capture cause, saved pc and trap value at detection
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_cause <= '0;
      r_epc   <= '0;
      r_async <= 1'b0;
`ifdef TRAP_MTVAL_EN
      r_tval  <= '0;
`endif
    end else if (w_take_sync | w_take_async) begin
      r_cause <= w_take_sync ? w_sync_cause : w_irq_cause;
      r_epc   <= w_epc;
      r_async <= w_take_async;
`ifdef TRAP_MTVAL_EN
      r_tval  <= w_take_async ? 32'd0 : illegal_inst_i ? inst_i : w_ebreak ? 32'(w_epc) : 32'd0;
`endif
    end
  // registered outputs, one cycle behind the state that produces them
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_data       <= '0;
      r_int_assert <= 1'b0;
      r_int_addr   <= '0;
      r_ack        <= '0;
    end else begin
      r_we         <= w_we;
      r_waddr      <= w_waddr;
      r_data       <= w_data;
      r_int_assert <= w_int_assert;
      r_int_addr   <= w_int_addr;
      r_ack        <= w_take_async ? w_onehot : '0;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Parametrised machine-mode trap controller sitting between decode/execute and csr_reg. It arbitrates synchronous exceptions (ECALL, EBREAK, illegal instruction), N prioritised asynchronous interrupt sources and MRET. It sequences the CSR writes (mepc, mstatus, mcause, optional mtval) one per cycle, then redirects the PC to the trap handler (direct or vectored) or to mepc.
It stalls the pipeline for the whole sequence.

Parameters:
IRQ_NUM, 4, number of interrupt sources (1..16); index 0 is highest priority.
ADDR_W, 32, instruction address width (<= 32).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
irq_i  in  IRQ_NUM  level interrupt requests
irq_en_i  in  IRQ_NUM  per-source enable (mie image)
global_int_en_i  in  1  mstatus.MIE
inst_i  in  32  instruction in decode
inst_addr_i  in  ADDR_W  its address
illegal_inst_i  in  1  decode flags inst_i illegal
jump_flag_i  in  1  execute redirect this cycle
jump_addr_i  in  ADDR_W  redirect target
csr_mtvec  in  32  mtvec
csr_mepc  in  32  mepc
csr_mstatus  in  32  mstatus
hold_flag_o  out  1  pipeline stall to ctrl
we_o  out  1  CSR write enable
waddr_o  out  32  CSR write address (zero-extended 12-bit)
data_o  out  32  CSR write data
int_assert_o  out  1  one-cycle PC redirect strobe to ex
int_addr_o  out  ADDR_W  redirect target
irq_ack_o  out  IRQ_NUM  one-hot, one-cycle ack of the taken source

Behaviour:
- Reset (async, rstn=0): state IDLE. Registered outputs we_o, waddr_o, data_o, int_assert_o, int_addr_o, irq_ack_o all 0. Cause and saved-pc registers are 0. The effect is immediate, including mid-sequence; no partial sequence resumes after reset.
- Arbitration (combinational, evaluated only in IDLE): sync > async > MRET.
  - sync = ECALL | EBREAK | illegal_inst_i.
  - async = |(irq_i & irq_en_i) & global_int_en_i.
  - The lowest set index wins.
- Cause codes:
  - Sync: ECALL 0x0000000B, EBREAK 0x00000003, illegal 0x00000002. If illegal_inst_i coincides with ECALL/EBREAK, illegal wins.
  - Async source i: bit31 set; code 3/7/11 for i=0/1/2, 16+(i-3) for i>=3.
- Saved pc, captured in IDLE on detection:
  - If jump_flag_i=1: jump_addr_i.
  - Else sync ECALL/EBREAK: inst_addr_i+4.
  - Else illegal: inst_addr_i.
  - Else async: inst_addr_i.
- FSM states: IDLE, MEPC, MSTATUS, MCAUSE, [MTVAL], MRET.
  - IDLE->MEPC on trap.
  - IDLE->MRET on MRET.
  - MEPC->MSTATUS->MCAUSE->(MTVAL->)IDLE.
  - MRET->IDLE.
- Outputs are registered from the state, so the write is visible one cycle after the state is entered. With detection in cycle T:
  - mepc write in T+2.
  - mstatus write in T+3, data = {ms[31:8], MPIE=ms[3], ms[6:4], MIE=0, ms[2:0]}.
  - mcause write in T+4.
  - int_assert_o=1 in the cycle after the final CSR-write state (T+4 without MTVAL).
  - In all other cycles we_o=0 and waddr_o/data_o=0.
- Redirect target:
  - Sync, or csr_mtvec[1:0]!=01: {csr_mtvec[31:2],2'b00}.
  - Async with vectored mode (csr_mtvec[1:0]=01): base + 4*cause_code[4:0].
- MRET:
  - mstatus write in T+2, data = {ms[31:8], MPIE=1, ms[6:4], MIE=ms[7], ms[2:0]}.
  - int_assert_o=1, int_addr_o=csr_mepc in T+2.
- irq_ack_o pulses one-hot for the taken source in T+1. An IRQ dropped after T still completes the sequence with the captured cause.
- hold_flag_o = (trap or MRET detected in IDLE) | (state != IDLE). It is combinational and asserted from T through the int_assert_o cycle inclusive.
- Inputs outside IDLE are ignored; no queueing. Pending level IRQs are re-evaluated on return to IDLE (masked by the cleared MIE).

Optional Feature:
TRAP_MTVAL_EN:
- When defined, an MTVAL state follows MCAUSE and writes CSR 0x343:
  - illegal: inst_i captured at T.
  - EBREAK: saved pc.
  - all others: 0.
- Sync-trap int_assert_o moves to T+5. Async traps also pass through MTVAL (writing 0) for uniform latency.
- When undefined, there is no MTVAL state and no 0x343 writes.

Test Plan:
- ECALL at 0x100, no jump -> mepc=0x104 (T+2), mstatus MIE=0 with MPIE=old MIE (T+3), mcause=0xB (T+4), int_assert_o with int_addr_o=mtvec base (T+4). hold_flag_o is high for T..T+4.
- MIE=1, irq_i=4'b0110, irq_en_i=4'b1111, mtvec=0x1001 -> source 1 taken, irq_ack_o=0010, mcause=0x80000007, int_addr_o=0x101C.
- ECALL together with irq_i=0001 -> sync handled (mcause=0xB). The IRQ is not acked until after MRET restores MIE.
- MRET with mepc=0x200, mstatus=0x80 -> mstatus written 0x88 and int_addr_o=0x200 in T+2, then back to IDLE.
- jump_flag_i=1 with jump_addr_i=0x300 and an IRQ -> mepc=0x300.
- rstn pulsed low during MSTATUS -> all outputs 0 immediately and no mcause write afterwards. With TRAP_MTVAL_EN, illegal inst 0xFFFFFFFF -> mtval=0xFFFFFFFF at T+5.
